// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender.
// Each accepted beat is extended into a 2-entry output buffer. The buffer
// head drives out_data/out_err, and there is no path from in_* to out_*.
// err_cnt counts errored beats at acceptance and saturates at its maximum.
module ext_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int OFS_W    = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [OFS_W-1:0]    in_ofs,
  input  logic [2:0]          ext_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_SIGN = 3'd1,
    OP_LUI  = 3'd2,
    OP_LB   = 3'd3,
    OP_LBU  = 3'd4,
    OP_LH   = 3'd5,
    OP_LHU  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // Each buffer entry is {err, data}.
  logic [DATA_W:0]     slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IMM_W-1:0]  imm_w;
  logic [DATA_W+7:0] pad_w;
  logic [7:0]        byte_w;
  logic [15:0]       half_w;
  logic              half_bad_w;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              push, pop;

  assign imm_w = in_data[IMM_W-1:0];
  // A zero byte above the word keeps the top-lane halfword select in range.
  // That lane is flagged as an error and never used as a result.
  assign pad_w = {8'h00, in_data};

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = slot0_q[DATA_W-1:0];
  assign out_err   = slot0_q[DATA_W];
  assign err_cnt   = err_cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Little-endian lane select of the byte and halfword at in_ofs.
  always_comb begin
    byte_w = '0;
    half_w = '0;
    for (int i = 0; i < NB; i++) begin
      if (in_ofs == OFS_W'(i)) begin
        byte_w = in_data[8*i +: 8];
        half_w = pad_w[8*i +: 16];
      end
    end
  end

  // A halfword is unusable when it is misaligned or runs past the word end.
  assign half_bad_w = in_ofs[0] || (in_ofs == OFS_W'(NB - 1));

  // Compute the extended result for the beat on the input.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_e'(ext_op))
      OP_ZERO: res_data = {{(DATA_W-IMM_W){1'b0}}, imm_w};
      OP_SIGN: res_data = {{(DATA_W-IMM_W){imm_w[IMM_W-1]}}, imm_w};
      OP_LUI:  res_data = {imm_w, {(DATA_W-IMM_W){1'b0}}};
      OP_LB:   res_data = {{(DATA_W-8){byte_w[7]}}, byte_w};
      OP_LBU:  res_data = {{(DATA_W-8){1'b0}}, byte_w};
      OP_LH: begin
        if (half_bad_w) res_err = 1'b1;
        else            res_data = {{(DATA_W-16){half_w[15]}}, half_w};
      end
      OP_LHU: begin
        if (half_bad_w) res_err = 1'b1;
        else            res_data = {{(DATA_W-16){1'b0}}, half_w};
      end
      default: res_err = 1'b1;
    endcase
  end

  // Two-slot FIFO next state. slot0 is always the head.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = {res_err, res_data};
        else               slot1_d = {res_err, res_data};
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = {res_err, res_data};
        end else begin
          slot0_d = slot1_q;
          slot1_d = {res_err, res_data};
        end
      end
      default: ;
    endcase
  end

  // Errored beats count at acceptance. The counter holds at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && res_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  // Buffer and counter registers. Reset drops any buffered beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q   <= '0;
      slot1_q   <= '0;
      cnt_q     <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe (ERRCNT_W=2 to reach saturation).
// Stimulus pushes the expected {err, data} per beat. The monitor pops and
// compares at each output transfer. Inputs change 1 time unit after a rising
// edge, and the monitor samples on the falling edge.
module tb_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_ofs;
  logic [2:0]  ext_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  err_cnt;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [32:0] sb[$];
  int          errcnt_m = 0;

  ext_pipe #(.DATA_W(32), .IMM_W(16), .OFS_W(2), .ERRCNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ofs    (in_ofs),
    .ext_op    (ext_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // The monitor checks each output transfer, which completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_err", 32'(out_err), 32'(e[32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Holds a beat until it is accepted. Returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [1:0] ofs, input logic [2:0] op,
                      input logic [31:0] exp_d, input logic exp_e, input bit track);
    bit acc;
    int tries;
    if (track) sb.push_back({exp_e, exp_d});
    if (exp_e) errcnt_m = (errcnt_m == 3) ? 3 : errcnt_m + 1;
    in_valid = 1'b1;
    in_data  = d;
    in_ofs   = ofs;
    ext_op   = op;
    tries    = 0;
    acc      = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // Sends one beat and checks that the result appears in the next cycle and then clears.
  task automatic one_beat(input logic [31:0] d, input logic [2:0] op, input logic [31:0] exp_d);
    send(d, 2'd0, op, exp_d, 1'b0, 1'b1);
    chk("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c0;
    logic [15:0] imm;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ofs    = '0;
    ext_op    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Immediate ops. The upper half is junk and must be ignored.
    one_beat(32'hdead_fe34, 3'd0, 32'h0000fe34);
    one_beat(32'hdead_fe34, 3'd1, 32'hfffffe34);
    one_beat(32'hdead_fe34, 3'd2, 32'hfe340000);

    // Load lanes.
    send(32'h80a1_7f42, 2'd0, 3'd3, 32'h00000042, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd1, 3'd3, 32'h0000007f, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd2, 3'd3, 32'hffffffa1, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd3, 3'd3, 32'hffffff80, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd3, 3'd4, 32'h00000080, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd2, 3'd5, 32'hffff80a1, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd0, 3'd6, 32'h00007f42, 1'b0, 1'b1);
    send(32'h80a1_7f42, 2'd2, 3'd6, 32'h000080a1, 1'b0, 1'b1);
    chk("err_cnt_clean", 32'(err_cnt), 32'd0);
    send(32'h80a1_7f42, 2'd1, 3'd5, 32'h00000000, 1'b1, 1'b1);
    chk("err_cnt_lh_mis", 32'(err_cnt), 32'd1);
    send(32'h80a1_7f42, 2'd0, 3'd7, 32'h00000000, 1'b1, 1'b1);
    chk("err_cnt_op7", 32'(err_cnt), 32'd2);
    drain();

    // Backpressure: two beats fill the buffer, and the third must wait for a pop.
    out_ready = 1'b0;
    send(32'h0000_8001, 2'd0, 3'd1, 32'hffff8001, 1'b0, 1'b1);
    send(32'h0000_1234, 2'd0, 3'd1, 32'h00001234, 1'b0, 1'b1);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    sb.push_back({1'b0, 32'hffffc000});
    in_valid = 1'b1;
    in_data  = 32'h0000_c000;
    ext_op   = 3'd1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_data", out_data, 32'hffff8001);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Streaming at one beat per cycle.
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      imm = 16'h7ffb + 16'(i);
      send({16'h5a5a, imm}, 2'd0, 3'd1, {{16{imm[15]}}, imm}, 1'b0, 1'b1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd10);
    drain();

    // Saturation from 2: 3, then held at 3.
    send(32'h0, 2'd0, 3'd7, 32'h0, 1'b1, 1'b1);
    chk("sat_cnt", 32'(err_cnt), 32'(errcnt_m));
    send(32'h1234_5678, 2'd3, 3'd5, 32'h0, 1'b1, 1'b1);
    chk("sat_cnt", 32'(err_cnt), 32'(errcnt_m));
    send(32'h1234_5678, 2'd1, 3'd6, 32'h0, 1'b1, 1'b1);
    chk("sat_cnt", 32'(err_cnt), 32'(errcnt_m));
    send(32'h1234_5678, 2'd3, 3'd6, 32'h0, 1'b1, 1'b1);
    chk("sat_cnt", 32'(err_cnt), 32'(errcnt_m));
    send(32'hffff_ffff, 2'd2, 3'd7, 32'h0, 1'b1, 1'b1);
    chk("sat_cnt_final", 32'(err_cnt), 32'd3);
    drain();

    // Reset with two beats buffered. Both beats must be lost.
    out_ready = 1'b0;
    send(32'h0, 2'd0, 3'd7, 32'h0, 1'b1, 1'b0);
    send(32'h80a1_7f42, 2'd0, 3'd3, 32'h00000042, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_errcnt", 32'(err_cnt), 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    errcnt_m  = 0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready2", 32'(in_ready), 32'd1);
    end
    send(32'h80a1_7f42, 2'd1, 3'd4, 32'h0000007f, 1'b0, 1'b1);
    send(32'h0, 2'd0, 3'd7, 32'h0, 1'b1, 1'b1);
    chk("post_rst_errcnt", 32'(err_cnt), 32'(errcnt_m));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Performs immediate extension (zero, sign, LUI) and load-data extraction/extension (byte and halfword, signed and unsigned, with lane select) on a DATA_W-bit word.
- Sits between the decode/MEM stage and writeback.
- Uses a valid/ready handshake, a 2-entry output buffer, and a saturating error counter.

Parameters:
- DATA_W, 32: datapath width in bits; must be a multiple of 16 and at least 32.
- IMM_W, 16: immediate width in bits; must be less than DATA_W.
- OFS_W, 2: byte-offset width; must equal clog2(DATA_W/8).
- ERRCNT_W, 8: width of the error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  immediate in bits [IMM_W-1:0] (ops 0-2) or raw memory word (ops 3-6).
- in_ofs  in  OFS_W  byte offset for ops 3-6; ignored for ops 0-2.
- ext_op  in  3  0 ZERO, 1 SIGN, 2 LUI, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  extended result.
- out_err  out  1  error flag accompanying out_data.
- err_cnt  out  ERRCNT_W  saturating count of errored beats accepted.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Buffer count=0; out_valid=0, out_data=0, out_err=0, err_cnt=0.
  - in_ready=1 from the first edge after deassert.
  - Reset mid-operation discards all buffered beats with no output.
- Transfers:
  - Input transfer when in_valid&&in_ready at a rising edge.
  - Output transfer when out_valid&&out_ready.
- Latency: a beat accepted at edge N is presented at out_* after edge N (visible in cycle N+1). There is no combinational path from in_* to out_*.
- Buffer: 2-entry FIFO of {out_data, out_err}; count ranges 0..2.
  - in_ready = (count<2), a function of registered state only; it must not depend on out_ready.
  - out_valid = (count>0); out_data/out_err show the head entry.
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged and order preserved.
  - Count=2: in_ready=0; a pop that cycle frees a slot from the next cycle.
  - Holding stable: out_data/out_err are held stable while out_valid&&!out_ready.
  - Full throughput: 1 beat/cycle sustained when out_ready is held high.
- Computation (on accept):
  - ZERO: zero-extend in_data[IMM_W-1:0] to DATA_W.
  - SIGN: sign-extend in_data[IMM_W-1:0] to DATA_W.
  - LUI: {in_data[IMM_W-1:0], zeros} truncated/padded to DATA_W (immediate occupies the top IMM_W bits).
  - LB/LBU: byte = in_data[8*ofs+7 : 8*ofs]; sign- or zero-extend to DATA_W (little-endian lanes).
  - LH/LHU: half = in_data[8*ofs+15 : 8*ofs]; sign- or zero-extend.
  - LH/LHU misaligned (ofs[0]=1) or half crossing the word end: out_data=0, out_err=1.
  - Op 7: out_data=0, out_err=1.
  - All other results: out_err=0.
- err_cnt:
  - Increments on acceptance of an errored beat, not on output.
  - Saturates at 2^ERRCNT_W-1; it never wraps.
  - Cleared only by reset.

Test Plan:
- Reset release, then a single beat of each op 0-2 with in_data[15:0]=16'hfe34, out_ready=1. Required per op: out_valid one cycle after accept.
  - ZERO → 32'h0000fe34.
  - SIGN → 32'hfffffe34.
  - LUI → 32'hfe340000.
  - out_err=0 throughout.
- in_data=32'h80a1_7f42, LB with ofs 0..3 → 32'h00000042, 32'h0000007f, 32'hffffffa1, 32'hffffff80. LBU with ofs 3 → 32'h00000080.
- Same word:
  - LH ofs 2 → 32'hffff80a1; LHU ofs 0 → 32'h00007f42.
  - LH ofs 1 → out_data=0, out_err=1, err_cnt=1.
  - Op 7 → err_cnt=2.
- Backpressure: out_ready=0, stream 3 SIGN beats → first two accepted, in_ready=0 on the third, out_data held stable. Then raise out_ready → beats drain in order, and the third is accepted in the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with incrementing immediates → 10 in-order results, count never exceeds 1, in_ready stays 1.
- With ERRCNT_W=2, feed 5 errored beats → err_cnt saturates at 3. Then assert rst_n=0 mid-stream with 2 beats buffered → out_valid=0 and err_cnt=0 immediately (asynchronous), and no stale beat appears after release.
